// File: rtl/cyclotron_trace_arbiter.sv
// cyclotron_trace_arbiter
//   Collects writeback traces from up to four execution-unit sources into
//   per-source FIFOs and serializes them onto the three-slot difftest trace
//   port. Writebacks of the same instruction (pc, warp, tmask) arriving from
//   different sources in the same cycle are merged into one beat.
//   Optional feature macro: CYCLOTRON_TRACE_ARB_PERF_EN (stall-cycle counter).
module cyclotron_trace_arbiter #(
   parameter int NUM_SRCS   = 3,
   parameter int ARCH_LEN   = 32,
   parameter int NUM_WARPS  = 8,
   parameter int NUM_LANES  = 16,
   parameter int REG_BITS   = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                      clock,
   input  logic                                      reset,
   input  logic [NUM_SRCS-1:0]                       src_valid,
   output logic [NUM_SRCS-1:0]                       src_ready,
   input  logic [NUM_SRCS*ARCH_LEN-1:0]              src_pc,
   input  logic [NUM_SRCS*$clog2(NUM_WARPS)-1:0]     src_warpId,
   input  logic [NUM_SRCS*NUM_LANES-1:0]             src_tmask,
   input  logic [NUM_SRCS-1:0]                       src_rd_en,
   input  logic [NUM_SRCS*REG_BITS-1:0]              src_rd_addr,
   input  logic [NUM_SRCS*NUM_LANES*ARCH_LEN-1:0]    src_rd_data,
   output logic                                      trace_valid,
   output logic [ARCH_LEN-1:0]                       trace_pc,
   output logic [$clog2(NUM_WARPS)-1:0]              trace_warpId,
   output logic [NUM_LANES-1:0]                      trace_tmask,
   output logic                                      trace_regs_0_enable,
   output logic [REG_BITS-1:0]                       trace_regs_0_address,
   output logic [NUM_LANES*ARCH_LEN-1:0]             trace_regs_0_data,
   output logic                                      trace_regs_1_enable,
   output logic [REG_BITS-1:0]                       trace_regs_1_address,
   output logic [NUM_LANES*ARCH_LEN-1:0]             trace_regs_1_data,
   output logic                                      trace_regs_2_enable,
   output logic [REG_BITS-1:0]                       trace_regs_2_address,
   output logic [NUM_LANES*ARCH_LEN-1:0]             trace_regs_2_data,
   output logic [31:0]                               perf_stall_cycles
);

   localparam int WID = $clog2(NUM_WARPS);
   localparam int DW  = NUM_LANES * ARCH_LEN;
   localparam int SW  = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = PW + 1;

   typedef struct packed {
      logic [ARCH_LEN-1:0]  pc;
      logic [WID-1:0]       warp;
      logic [NUM_LANES-1:0] tmask;
      logic                 rd_en;
      logic [REG_BITS-1:0]  rd_addr;
      logic [DW-1:0]        rd_data;
   } entry_t;

   if (NUM_SRCS < 1 || NUM_SRCS > 4) begin : g_bad_srcs
      $error("cyclotron_trace_arbiter: NUM_SRCS=%0d outside 1..4", NUM_SRCS);
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("cyclotron_trace_arbiter: FIFO_DEPTH=%0d must be a power of two >= 2", FIFO_DEPTH);
   end

   entry_t              head [NUM_SRCS];
   logic [NUM_SRCS-1:0] head_vld;
   logic [NUM_SRCS-1:0] push;
   logic [NUM_SRCS-1:0] pop;

   // ---------------------------------------------------------------------
   // Per-source FIFOs
   // ---------------------------------------------------------------------
   for (genvar i = 0; i < NUM_SRCS; i++) begin : g_src
      entry_t          mem [FIFO_DEPTH];
      entry_t          in_ent;
      logic [PW-1:0]   wr_ptr;
      logic [PW-1:0]   rd_ptr;
      logic [CW-1:0]   count;

      assign in_ent = {src_pc[i*ARCH_LEN +: ARCH_LEN],
                       src_warpId[i*WID +: WID],
                       src_tmask[i*NUM_LANES +: NUM_LANES],
                       src_rd_en[i],
                       src_rd_addr[i*REG_BITS +: REG_BITS],
                       src_rd_data[i*DW +: DW]};

      // ready comes from the registered count only, so a full FIFO stays
      // closed for the cycle it pops
      assign src_ready[i] = (count != CW'(FIFO_DEPTH));
      assign push[i]      = src_valid[i] & src_ready[i];
      assign head_vld[i]  = (count != '0);
      assign head[i]      = mem[rd_ptr];

      // entry storage; no reset needed, validity is tracked by count
      always_ff @(posedge clock) begin
         if (push[i]) mem[wr_ptr] <= in_ent;
      end

      // pointers and occupancy; reset drops everything still queued
      always_ff @(posedge clock) begin
         if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push[i]) wr_ptr <= wr_ptr + PW'(1);
            if (pop[i])  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push[i]) - CW'(pop[i]);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Arbitration and coalescing
   // ---------------------------------------------------------------------
   logic [SW-1:0] rr_ptr;
   logic [SW-1:0] win;
   logic [SW-1:0] idx_a;
   logic [SW-1:0] idx_c;
   logic [SW-1:0] sel1;
   logic [SW-1:0] sel2;
   logic          any_vld;
   logic          sel1_vld;
   logic          sel2_vld;

   // round-robin winner: first non-empty head at or after rr_ptr
   always_comb begin
      any_vld = 1'b0;
      win     = '0;
      idx_a   = '0;
      for (int k = 0; k < NUM_SRCS; k++) begin
         idx_a = SW'((int'(rr_ptr) + k) % NUM_SRCS);
         if (!any_vld && head_vld[idx_a]) begin
            any_vld = 1'b1;
            win     = idx_a;
         end
      end
   end

   // merge matching heads after the winner into slots 1 and 2, pop all users
   always_comb begin
      sel1_vld = 1'b0;
      sel2_vld = 1'b0;
      sel1     = '0;
      sel2     = '0;
      idx_c    = '0;
      pop      = '0;
      if (any_vld) pop[win] = 1'b1;
      for (int k = 1; k < NUM_SRCS; k++) begin
         idx_c = SW'((int'(win) + k) % NUM_SRCS);
         if (any_vld && head_vld[idx_c] && head[idx_c].rd_en &&
             head[idx_c].pc == head[win].pc && head[idx_c].warp == head[win].warp &&
             head[idx_c].tmask == head[win].tmask) begin
            if (!sel1_vld) begin
               sel1_vld   = 1'b1;
               sel1       = idx_c;
               pop[idx_c] = 1'b1;
            end else if (!sel2_vld) begin
               sel2_vld   = 1'b1;
               sel2       = idx_c;
               pop[idx_c] = 1'b1;
            end
         end
      end
   end

   // round-robin pointer advances past the winner whenever a beat goes out
   always_ff @(posedge clock) begin
      if (reset)        rr_ptr <= '0;
      else if (any_vld) rr_ptr <= SW'((int'(win) + 1) % NUM_SRCS);
   end

   // registered trace beat; everything is zero on idle cycles
   always_ff @(posedge clock) begin
      if (reset) begin
         trace_valid          <= 1'b0;
         trace_pc             <= '0;
         trace_warpId         <= '0;
         trace_tmask          <= '0;
         trace_regs_0_enable  <= 1'b0;
         trace_regs_0_address <= '0;
         trace_regs_0_data    <= '0;
         trace_regs_1_enable  <= 1'b0;
         trace_regs_1_address <= '0;
         trace_regs_1_data    <= '0;
         trace_regs_2_enable  <= 1'b0;
         trace_regs_2_address <= '0;
         trace_regs_2_data    <= '0;
      end else begin
         trace_valid          <= any_vld;
         trace_pc             <= any_vld  ? head[win].pc      : '0;
         trace_warpId         <= any_vld  ? head[win].warp    : '0;
         trace_tmask          <= any_vld  ? head[win].tmask   : '0;
         trace_regs_0_enable  <= any_vld  & head[win].rd_en;
         trace_regs_0_address <= any_vld  ? head[win].rd_addr : '0;
         trace_regs_0_data    <= any_vld  ? head[win].rd_data : '0;
         trace_regs_1_enable  <= sel1_vld;
         trace_regs_1_address <= sel1_vld ? head[sel1].rd_addr : '0;
         trace_regs_1_data    <= sel1_vld ? head[sel1].rd_data : '0;
         trace_regs_2_enable  <= sel2_vld;
         trace_regs_2_address <= sel2_vld ? head[sel2].rd_addr : '0;
         trace_regs_2_data    <= sel2_vld ? head[sel2].rd_data : '0;
      end
   end

   // ---------------------------------------------------------------------
   // Optional stall counter
   // ---------------------------------------------------------------------
`ifdef CYCLOTRON_TRACE_ARB_PERF_EN
   logic [31:0] stall_q;

   // saturating count of cycles where some source is refused
   always_ff @(posedge clock) begin
      if (reset)
         stall_q <= '0;
      else if ((|(src_valid & ~src_ready)) && stall_q != 32'hFFFF_FFFF)
         stall_q <= stall_q + 32'd1;
   end

   assign perf_stall_cycles = stall_q;
`else
   assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_cyclotron_trace_arbiter.sv
// Randomized + directed bench for cyclotron_trace_arbiter with a queue-based
// reference model checked every cycle.
module tb_cyclotron_trace_arbiter;

   localparam int NS  = 3;
   localparam int AL  = 32;
   localparam int NW  = 8;
   localparam int WD  = 3;
   localparam int NL  = 16;
   localparam int RB  = 8;
   localparam int DEP = 4;
   localparam int DW  = NL * AL;

   logic              clock = 1'b0;
   logic              reset;
   logic [NS-1:0]     src_valid;
   logic [NS-1:0]     src_ready;
   logic [NS*AL-1:0]  src_pc;
   logic [NS*WD-1:0]  src_warpId;
   logic [NS*NL-1:0]  src_tmask;
   logic [NS-1:0]     src_rd_en;
   logic [NS*RB-1:0]  src_rd_addr;
   logic [NS*DW-1:0]  src_rd_data;
   logic              trace_valid;
   logic [AL-1:0]     trace_pc;
   logic [WD-1:0]     trace_warpId;
   logic [NL-1:0]     trace_tmask;
   logic              t0_en, t1_en, t2_en;
   logic [RB-1:0]     t0_addr, t1_addr, t2_addr;
   logic [DW-1:0]     t0_data, t1_data, t2_data;
   logic [31:0]       perf_stall_cycles;

   always #5 clock = ~clock;

   cyclotron_trace_arbiter #(
      .NUM_SRCS(NS), .ARCH_LEN(AL), .NUM_WARPS(NW), .NUM_LANES(NL),
      .REG_BITS(RB), .FIFO_DEPTH(DEP)
   ) dut (
      .clock(clock), .reset(reset),
      .src_valid(src_valid), .src_ready(src_ready), .src_pc(src_pc),
      .src_warpId(src_warpId), .src_tmask(src_tmask), .src_rd_en(src_rd_en),
      .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
      .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_warpId(trace_warpId),
      .trace_tmask(trace_tmask),
      .trace_regs_0_enable(t0_en), .trace_regs_0_address(t0_addr), .trace_regs_0_data(t0_data),
      .trace_regs_1_enable(t1_en), .trace_regs_1_address(t1_addr), .trace_regs_1_data(t1_data),
      .trace_regs_2_enable(t2_en), .trace_regs_2_address(t2_addr), .trace_regs_2_data(t2_data),
      .perf_stall_cycles(perf_stall_cycles)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [AL-1:0] pc;
      logic [WD-1:0] warp;
      logic [NL-1:0] tmask;
      logic          en;
      logic [RB-1:0] addr;
      logic [DW-1:0] data;
   } ent_t;

   ent_t        q [NS][$];
   int          rr = 0;
   logic [31:0] stall = 0;
   logic        e_valid;
   logic [AL-1:0] e_pc;
   logic [WD-1:0] e_warp;
   logic [NL-1:0] e_tmask;
   logic          e_en   [3];
   logic [RB-1:0] e_addr [3];
   logic [DW-1:0] e_data [3];

   task automatic clear_exp();
      e_valid = 0; e_pc = '0; e_warp = '0; e_tmask = '0;
      for (int k = 0; k < 3; k++) begin e_en[k] = 0; e_addr[k] = '0; e_data[k] = '0; end
   endtask

   // one clock of the arbiter, from the inputs currently applied
   task automatic model_step();
      bit   acc [NS];
      bit   popm [NS];
      bit   refused;
      int   w;
      int   s;
      int   slot;
      ent_t h;
      ent_t e;
      refused = 0;
      w = -1;
      slot = 1;
      if (reset) begin
         for (int i = 0; i < NS; i++) q[i].delete();
         rr = 0;
         stall = 0;
         clear_exp();
         return;
      end
      for (int i = 0; i < NS; i++) begin
         acc[i]  = src_valid[i] && (q[i].size() < DEP);
         popm[i] = 0;
         if (src_valid[i] && q[i].size() == DEP) refused = 1;
      end
      if (refused && stall != 32'hFFFF_FFFF) stall = stall + 1;
      clear_exp();
      for (int k = 0; k < NS; k++) begin
         s = (rr + k) % NS;
         if (w < 0 && q[s].size() > 0) w = s;
      end
      if (w >= 0) begin
         h = q[w][0];
         e_valid = 1; e_pc = h.pc; e_warp = h.warp; e_tmask = h.tmask;
         e_en[0] = h.en; e_addr[0] = h.addr; e_data[0] = h.data;
         popm[w] = 1;
         for (int k = 1; k < NS; k++) begin
            s = (w + k) % NS;
            if (slot < 3 && q[s].size() > 0 && q[s][0].en && q[s][0].pc == h.pc &&
                q[s][0].warp == h.warp && q[s][0].tmask == h.tmask) begin
               e_en[slot] = 1; e_addr[slot] = q[s][0].addr; e_data[slot] = q[s][0].data;
               popm[s] = 1;
               slot++;
            end
         end
         rr = (w + 1) % NS;
      end
      for (int i = 0; i < NS; i++) if (popm[i]) void'(q[i].pop_front());
      for (int i = 0; i < NS; i++) if (acc[i]) begin
         e.pc = src_pc[i*AL +: AL]; e.warp = src_warpId[i*WD +: WD];
         e.tmask = src_tmask[i*NL +: NL]; e.en = src_rd_en[i];
         e.addr = src_rd_addr[i*RB +: RB]; e.data = src_rd_data[i*DW +: DW];
         q[i].push_back(e);
      end
   endtask

   // every-cycle comparison of all outputs against the model
   task automatic compare_all();
      logic [NS-1:0] exp_rdy;
      for (int i = 0; i < NS; i++) exp_rdy[i] = (q[i].size() < DEP);
      check("ready",   DW'(src_ready),    DW'(exp_rdy));
      check("valid",   DW'(trace_valid),  DW'(e_valid));
      check("pc",      DW'(trace_pc),     DW'(e_pc));
      check("warp",    DW'(trace_warpId), DW'(e_warp));
      check("tmask",   DW'(trace_tmask),  DW'(e_tmask));
      check("s0_en",   DW'(t0_en),   DW'(e_en[0]));
      check("s0_addr", DW'(t0_addr), DW'(e_addr[0]));
      check("s0_data", t0_data, e_data[0]);
      check("s1_en",   DW'(t1_en),   DW'(e_en[1]));
      check("s1_addr", DW'(t1_addr), DW'(e_addr[1]));
      check("s1_data", t1_data, e_data[1]);
      check("s2_en",   DW'(t2_en),   DW'(e_en[2]));
      check("s2_addr", DW'(t2_addr), DW'(e_addr[2]));
      check("s2_data", t2_data, e_data[2]);
`ifdef CYCLOTRON_TRACE_ARB_PERF_EN
      check("perf", DW'(perf_stall_cycles), DW'(stall));
`else
      check("perf", DW'(perf_stall_cycles), DW'(0));
`endif
   endtask

   // ---------------- stimulus helpers ----------------
   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] d;
      for (int k = 0; k < NL; k++) d[k*AL +: AL] = $urandom();
      return d;
   endfunction

   task automatic clear_in();
      src_valid = '0; src_pc = '0; src_warpId = '0; src_tmask = '0;
      src_rd_en = '0; src_rd_addr = '0; src_rd_data = '0;
   endtask

   task automatic set_src(input int i, input logic v, input logic [AL-1:0] pc,
                          input logic [WD-1:0] w, input logic [NL-1:0] tm,
                          input logic en, input logic [RB-1:0] a, input logic [DW-1:0] d);
      src_valid[i] = v; src_pc[i*AL +: AL] = pc; src_warpId[i*WD +: WD] = w;
      src_tmask[i*NL +: NL] = tm; src_rd_en[i] = en; src_rd_addr[i*RB +: RB] = a;
      src_rd_data[i*DW +: DW] = d;
   endtask

   task automatic step();
      model_step();
      @(posedge clock);
      @(negedge clock);
      compare_all();
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   logic [DW-1:0] d0, d2;
   logic [AL-1:0] beats [$];

   initial begin
      clear_in();
      reset = 1'b1;
      @(negedge clock);
      step();
      step();
      reset = 1'b0;
      check("rst_ready", DW'(src_ready), DW'(3'b111));
      check("rst_valid", DW'(trace_valid), DW'(0));
      check("rst_perf",  DW'(perf_stall_cycles), DW'(0));

      // single push from src0
      set_src(0, 1, 32'h100, 3'd2, 16'hFFFF, 1, 8'd5, rnd_data());
      step();
      clear_in();
      check("t1_lat_valid", DW'(trace_valid), DW'(0));
      step();
      check("t1_valid", DW'(trace_valid), DW'(1));
      check("t1_pc",    DW'(trace_pc),    DW'(32'h100));
      check("t1_s0",    DW'(t0_addr),     DW'(8'd5));
      check("t1_s1en",  DW'(t1_en),       DW'(0));
      check("t1_s2en",  DW'(t2_en),       DW'(0));
      step();
      check("t1_once", DW'(trace_valid), DW'(0));

      // coalesce src0 + src2
      reset_pulse();
      d0 = rnd_data();
      d2 = rnd_data();
      set_src(0, 1, 32'h200, 3'd1, 16'hFFFF, 1, 8'd3, d0);
      set_src(2, 1, 32'h200, 3'd1, 16'hFFFF, 1, 8'd7, d2);
      step();
      clear_in();
      step();
      check("co_valid", DW'(trace_valid), DW'(1));
      check("co_s0",    DW'(t0_addr),     DW'(8'd3));
      check("co_s1",    DW'(t1_addr),     DW'(8'd7));
      check("co_s1en",  DW'(t1_en),       DW'(1));
      check("co_s1d",   t1_data,          d2);
      check("co_s2en",  DW'(t2_en),       DW'(0));
      step();
      check("co_once", DW'(trace_valid), DW'(0));

      // round-robin and full FIFOs: every source pushes every cycle
      reset_pulse();
      for (int c = 0; c < 12; c++) begin
         for (int s = 0; s < NS; s++)
            set_src(s, 1, 32'h1000 + 32'(s) * 32'h100 + 32'(c) * 4, WD'(s), 16'hFFFF, 1,
                    RB'(c), rnd_data());
         step();
         if (trace_valid) beats.push_back(trace_pc);
         if (c == 4) check("full_ready", DW'(src_ready), DW'(3'b001));
`ifdef CYCLOTRON_TRACE_ARB_PERF_EN
         if (c == 5) check("full_perf", DW'(perf_stall_cycles), DW'(1));
`endif
      end
      clear_in();
      for (int c = 0; c < 14; c++) begin
         step();
         if (trace_valid) beats.push_back(trace_pc);
      end
      check("rr_beat0", DW'(beats[0]), DW'(32'h1000));
      check("rr_beat1", DW'(beats[1]), DW'(32'h1100));
      check("rr_beat2", DW'(beats[2]), DW'(32'h1200));
      check("rr_beat3", DW'(beats[3]), DW'(32'h1004));

      // reset mid-stream with queued entries
      for (int c = 0; c < 2; c++) begin
         for (int s = 0; s < NS; s++)
            set_src(s, 1, 32'h2000 + 32'(c * 16 + s), 3'd0, 16'h00FF, 1, 8'd1, rnd_data());
         step();
      end
      clear_in();
      reset_pulse();
      check("mr_ready", DW'(src_ready), DW'(3'b111));
      check("mr_valid", DW'(trace_valid), DW'(0));
      step();
      check("mr_quiet", DW'(trace_valid), DW'(0));
      set_src(1, 1, 32'h300, 3'd0, 16'h1, 1, 8'd9, rnd_data());
      set_src(0, 1, 32'h400, 3'd0, 16'h1, 1, 8'd8, rnd_data());
      step();
      clear_in();
      step();
      check("mr_rr0", DW'(trace_pc), DW'(32'h400));

      // randomized traffic with small pc/warp/tmask alphabets to force merges
      for (int c = 0; c < 600; c++) begin
         for (int s = 0; s < NS; s++)
            set_src(s, ($urandom_range(0, 9) < 6), 32'h500 + 32'($urandom_range(0, 1)) * 4,
                    WD'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h00FF,
                    ($urandom_range(0, 4) != 0), RB'($urandom()), rnd_data());
         reset = ($urandom_range(0, 199) == 0);
         step();
      end
      reset = 1'b0;
      clear_in();
      for (int c = 0; c < 16; c++) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cyclotron_trace_arbiter.md
# cyclotron_trace_arbiter

Per-core commit-trace arbiter that collects writeback traces from up to four execution-unit sources into per-source FIFOs and serializes them onto the single three-slot difftest trace port. Its outputs connect directly to the Cyclotron difftest blackbox. It coalesces writebacks belonging to the same instruction (same pc, warp and tmask) that arrive from different units into one trace beat, using register slots 0–2.

## Interface
- NUM_SRCS, 3, number of trace sources; legal range 1..4
- ARCH_LEN, 32, pc and per-lane data width
- NUM_WARPS, 8, warp count; WID = $clog2(NUM_WARPS)
- NUM_LANES, 16, lanes per warp
- REG_BITS, 8, register address width
- FIFO_DEPTH, 4, entries per source FIFO; power of two, ≥2
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- src_valid  in  NUM_SRCS  per-source entry valid
- src_ready  out  NUM_SRCS  per-source FIFO not full
- src_pc  in  NUM_SRCS*ARCH_LEN  packed pc; source i occupies bits [i*ARCH_LEN +: ARCH_LEN]
- src_warpId  in  NUM_SRCS*WID  packed warp id
- src_tmask  in  NUM_SRCS*NUM_LANES  packed thread mask
- src_rd_en  in  NUM_SRCS  writeback present
- src_rd_addr  in  NUM_SRCS*REG_BITS  destination register
- src_rd_data  in  NUM_SRCS*NUM_LANES*ARCH_LEN  per-lane writeback data; lane 0 in the LSBs
- trace_valid, trace_pc, trace_warpId, trace_tmask  out  1/ARCH_LEN/WID/NUM_LANES  registered trace beat
- trace_regs_k_enable, trace_regs_k_address, trace_regs_k_data (k=0..2)  out  1/REG_BITS/NUM_LANES*ARCH_LEN  slot k
- perf_stall_cycles  out  32  see Configuration

## Operation
- Push: each source has its own FIFO. An entry is written on src_valid[i] && src_ready[i].
- src_ready[i] = (count[i] != FIFO_DEPTH). It is computed from registered count only and has no same-cycle dependence on pops.
- Arbitration, evaluated every cycle over the FIFO heads:
  - Winner W is the first non-empty source at or after rr_ptr, scanning in ascending index order with wrap.
- Coalesce:
  - Scan the other sources in ascending order starting at W+1, with wrap.
  - A source matches when its head is non-empty, its rd_en=1, and its pc, warpId and tmask all equal the winner's.
  - Matching sources fill free slots in scan order. The winner always takes slot 0, so at most two sources coalesce.
- Pop: the winner and every coalesced source pop in the same cycle.
- rr_ptr update: rr_ptr <= (W+1) mod NUM_SRCS, applied only when some head is valid.
- Beat contents:
  - slot 0 carries the winner's rd_en, rd_addr and rd_data. A winner with rd_en=0 still produces a beat, with trace_regs_0_enable=0.
  - Unfilled slots drive enable=0, address=0 and data=0.
- Idle: when all FIFOs are empty the next cycle drives trace_valid=0, and all other trace outputs hold 0.
- Sources 4+ are not supported. Instances with NUM_SRCS>4 are rejected by an elaboration-time $error.

## Timing
- Reset:
  - All FIFOs empty, so src_ready is all-ones after reset is released.
  - rr_ptr=0, trace_valid=0, all trace outputs 0, perf_stall_cycles=0.
  - Reset asserted mid-operation discards all queued entries without emitting any beat.
- Latency: push at cycle t makes the entry a head at t+1, and trace_valid is driven at t+2. Minimum latency is 2 cycles.
- Throughput: one beat per cycle, with no backpressure from the trace side.
- Full FIFO: ready=0 for that cycle even if that FIFO pops in the same cycle. ready returns in the cycle after the pop.
- FIFO pointers wrap modulo FIFO_DEPTH. The count is $clog2(FIFO_DEPTH)+1 bits wide.
- Simultaneous push and pop on a non-full FIFO: the count is unchanged and entry order is preserved.

## Configuration
- CYCLOTRON_TRACE_ARB_PERF_EN
  - Defined: perf_stall_cycles is a saturating counter at 0xFFFF_FFFF. It increments once per cycle in which any src_valid[i] && !src_ready[i] holds, and is cleared by reset.
  - Undefined: perf_stall_cycles is tied to 0 and no counter logic is present.

## Test plan
- Single push, src0 pc=0x100, warp 2, rd_en=1, rd_addr=5 → exactly one beat 2 cycles later, slot 0 addr 5, slots 1 and 2 disabled.
- Coalesce: src0 and src2 push the same pc=0x200, warp 1, tmask=0xFFFF with addrs 3 and 7 → one beat with slot0=3, slot1=7, trace_valid for one cycle.
- Round-robin: all three sources push distinct pcs every cycle → beats emitted in order src0, src1, src2, src0…, with no source starved.
- Full: hold src1 valid for FIFO_DEPTH+2 cycles while other sources are busy → ready drops after 4 entries, no entry is lost or duplicated, and perf_stall_cycles counts the stall cycles when the macro is defined.
- Reset mid-stream with FIFOs half full → no beat after reset, src_ready=all-ones, rr_ptr restarts at src0.
